// File: rtl/lane_dly_pkg.sv
// Shared types and constants for the lane delay-line step sequencer.
package lane_dly_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StLoad,
    StMove,
    StGap,
    StHold,
    StDone
  } state_e;

  localparam logic SEL_RX = 1'b0;
  localparam logic SEL_TX = 1'b1;

  localparam int unsigned CNT_W_DEF = 8;
  // Width of the shared wait counter; covers timing parameters up to 15.
  localparam int unsigned WAIT_W    = 4;

endpackage

// File: rtl/lane_dly_wait_cnt.sv
// Loadable down-counter with zero flag; times the SETUP, GAP and HOLD windows.
module lane_dly_wait_cnt #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/lane_dly_step_seq.sv
// Delay-line step sequencer: pauses the HS IO clock, issues LOAD/MOVE pulses, reports status.
// Optional macro DLY_POS_TRACK_EN adds per-line tap position counters (RX_TAP_POS/TX_TAP_POS).
module lane_dly_step_seq
  import lane_dly_pkg::*;
#(
  parameter int unsigned PAUSE_SETUP = 3,
  parameter int unsigned MOVE_GAP    = 2,
  parameter int unsigned PAUSE_HOLD  = 3,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic             FAB_CLK,
  input  logic             RESET_N,
  input  logic             REQ_VALID,
  output logic             REQ_READY,
  input  logic             REQ_SEL,
  input  logic             REQ_DIR,
  input  logic             REQ_LOAD,
  input  logic [CNT_W-1:0] REQ_COUNT,
  output logic             DELAY_LINE_SEL,
  output logic             DELAY_LINE_DIRECTION,
  output logic             DELAY_LINE_LOAD,
  output logic             DELAY_LINE_MOVE,
  output logic             HS_IO_CLK_PAUSE,
  input  logic             RX_DELAY_LINE_OUT_OF_RANGE,
  input  logic             TX_DELAY_LINE_OUT_OF_RANGE,
  output logic             DONE,
  output logic             OOR,
  output logic [CNT_W-1:0] STEPS_DONE
`ifdef DLY_POS_TRACK_EN
  ,
  output logic [CNT_W-1:0] RX_TAP_POS,
  output logic [CNT_W-1:0] TX_TAP_POS
`endif
);

  localparam logic [WAIT_W-1:0] SetupLd = WAIT_W'(PAUSE_SETUP - 1);
  localparam logic [WAIT_W-1:0] GapLd   = WAIT_W'(MOVE_GAP - 1);
  localparam logic [WAIT_W-1:0] HoldLd  = WAIT_W'(PAUSE_HOLD - 1);

  state_e             state_q, state_d;
  logic               sel_q, dir_q, load_q;
  logic [CNT_W-1:0]   count_q;
  logic [CNT_W-1:0]   steps_q;
  logic               oor_q;
  logic               done_q;

  logic               accept;
  logic               sel_oor;
  logic               more;
  logic [CNT_W:0]     steps_nxt;
  logic               cnt_load;
  logic [WAIT_W-1:0]  cnt_val;
  logic               cnt_zero;
  logic               oor_set;
  logic               go_move, go_gap, go_hold;

  assign accept    = REQ_VALID && REQ_READY;
  assign sel_oor   = (sel_q == SEL_TX) ? TX_DELAY_LINE_OUT_OF_RANGE : RX_DELAY_LINE_OUT_OF_RANGE;
  // One bit wider so a count of 2^CNT_W-1 finishes instead of wrapping.
  assign steps_nxt = {1'b0, steps_q} + 1'b1;
  assign more      = steps_nxt < {1'b0, count_q};

  lane_dly_wait_cnt #(
    .W (WAIT_W)
  ) u_wait_cnt (
    .clk      (FAB_CLK),
    .rst_n    (RESET_N),
    .load     (cnt_load),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_val  = '0;
    oor_set  = 1'b0;
    go_move  = 1'b0;
    go_gap   = 1'b0;
    go_hold  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d  = StSetup;
          cnt_load = 1'b1;
          cnt_val  = SetupLd;
        end
      end
      StSetup: begin
        if (cnt_zero) begin
          if (load_q) begin
            state_d = StLoad;
          end else if (count_q != '0) begin
            go_move = 1'b1;
          end else begin
            go_hold = 1'b1;
          end
        end
      end
      StLoad: begin
        if (count_q == '0) begin
          go_hold = 1'b1;
        end else if (MOVE_GAP == 0) begin
          go_move = 1'b1;
        end else begin
          go_gap = 1'b1;
        end
      end
      StMove: begin
        if (!more) begin
          go_hold = 1'b1;
        end else if (MOVE_GAP == 0) begin
          go_move = 1'b1;
        end else begin
          go_gap = 1'b1;
        end
      end
      StGap: begin
        if (cnt_zero) begin
          go_move = 1'b1;
        end
      end
      StHold: begin
        if (cnt_zero) begin
          state_d = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // The out-of-range flag is checked just before every MOVE; a hit abandons the rest.
    if (go_move) begin
      if (sel_oor) begin
        oor_set = 1'b1;
        go_hold = 1'b1;
      end else begin
        state_d = StMove;
      end
    end
    if (go_gap) begin
      state_d  = StGap;
      cnt_load = 1'b1;
      cnt_val  = GapLd;
    end
    if (go_hold) begin
      state_d  = StHold;
      cnt_load = 1'b1;
      cnt_val  = HoldLd;
    end
  end

  always_ff @(posedge FAB_CLK) begin
    if (!RESET_N) begin
      state_q <= StIdle;
      sel_q   <= 1'b0;
      dir_q   <= 1'b0;
      load_q  <= 1'b0;
      count_q <= '0;
      steps_q <= '0;
      oor_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == StDone);
      if (accept) begin
        sel_q   <= REQ_SEL;
        dir_q   <= REQ_DIR;
        load_q  <= REQ_LOAD;
        count_q <= REQ_COUNT;
        steps_q <= '0;
        oor_q   <= 1'b0;
      end
      if (state_q == StMove) begin
        steps_q <= steps_nxt[CNT_W-1:0];
      end
      if (oor_set || ((state_q == StHold) && sel_oor)) begin
        oor_q <= 1'b1;
      end
    end
  end

`ifdef DLY_POS_TRACK_EN
  logic [CNT_W-1:0] rx_pos_q, tx_pos_q;
  logic [CNT_W-1:0] cur_pos, cur_pos_d;

  assign cur_pos = (sel_q == SEL_RX) ? rx_pos_q : tx_pos_q;

  always_comb begin
    cur_pos_d = cur_pos;
    if (state_q == StLoad) begin
      cur_pos_d = '0;
    end else if (state_q == StMove) begin
      if (dir_q) begin
        if (cur_pos != '1) cur_pos_d = cur_pos + 1'b1;
      end else begin
        if (cur_pos != '0) cur_pos_d = cur_pos - 1'b1;
      end
    end
  end

  always_ff @(posedge FAB_CLK) begin
    if (!RESET_N) begin
      rx_pos_q <= '0;
      tx_pos_q <= '0;
    end else if (sel_q == SEL_RX) begin
      rx_pos_q <= cur_pos_d;
    end else begin
      tx_pos_q <= cur_pos_d;
    end
  end

  assign RX_TAP_POS = rx_pos_q;
  assign TX_TAP_POS = tx_pos_q;
`endif

  assign REQ_READY            = (state_q == StIdle) && !done_q;
  assign DELAY_LINE_SEL       = sel_q;
  assign DELAY_LINE_DIRECTION = dir_q;
  assign DELAY_LINE_LOAD      = (state_q == StLoad);
  assign DELAY_LINE_MOVE      = (state_q == StMove);
  assign HS_IO_CLK_PAUSE      = (state_q == StSetup) || (state_q == StLoad) ||
                                (state_q == StMove)  || (state_q == StGap)  ||
                                (state_q == StHold);
  assign DONE                 = done_q;
  assign OOR                  = oor_q;
  assign STEPS_DONE           = steps_q;

endmodule

// File: tb/tb_lane_dly_step_seq.sv
// Directed bench for lane_dly_step_seq at default parameters; cycle 0 is the accept cycle.
module tb_lane_dly_step_seq;

  logic       FAB_CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       REQ_VALID = 1'b0;
  logic       REQ_READY;
  logic       REQ_SEL = 1'b0;
  logic       REQ_DIR = 1'b0;
  logic       REQ_LOAD = 1'b0;
  logic [7:0] REQ_COUNT = 8'd0;
  logic       DELAY_LINE_SEL, DELAY_LINE_DIRECTION, DELAY_LINE_LOAD, DELAY_LINE_MOVE;
  logic       HS_IO_CLK_PAUSE;
  logic       RX_DELAY_LINE_OUT_OF_RANGE = 1'b0;
  logic       TX_DELAY_LINE_OUT_OF_RANGE = 1'b0;
  logic       DONE, OOR;
  logic [7:0] STEPS_DONE;
`ifdef DLY_POS_TRACK_EN
  logic [7:0] RX_TAP_POS, TX_TAP_POS;
`endif

  int checks = 0;
  int errors = 0;

  int n_move, n_load, n_pause, done_cyc, first_mv, last_mv, min_gap, max_gap;
  int viol, pause_rises, first_pause, last_pause;

  lane_dly_step_seq dut (
    .FAB_CLK                    (FAB_CLK),
    .RESET_N                    (RESET_N),
    .REQ_VALID                  (REQ_VALID),
    .REQ_READY                  (REQ_READY),
    .REQ_SEL                    (REQ_SEL),
    .REQ_DIR                    (REQ_DIR),
    .REQ_LOAD                   (REQ_LOAD),
    .REQ_COUNT                  (REQ_COUNT),
    .DELAY_LINE_SEL             (DELAY_LINE_SEL),
    .DELAY_LINE_DIRECTION       (DELAY_LINE_DIRECTION),
    .DELAY_LINE_LOAD            (DELAY_LINE_LOAD),
    .DELAY_LINE_MOVE            (DELAY_LINE_MOVE),
    .HS_IO_CLK_PAUSE            (HS_IO_CLK_PAUSE),
    .RX_DELAY_LINE_OUT_OF_RANGE (RX_DELAY_LINE_OUT_OF_RANGE),
    .TX_DELAY_LINE_OUT_OF_RANGE (TX_DELAY_LINE_OUT_OF_RANGE),
    .DONE                       (DONE),
    .OOR                        (OOR),
    .STEPS_DONE                 (STEPS_DONE)
`ifdef DLY_POS_TRACK_EN
    ,
    .RX_TAP_POS                 (RX_TAP_POS),
    .TX_TAP_POS                 (TX_TAP_POS)
`endif
  );

  always #5 FAB_CLK = ~FAB_CLK;

  task automatic tick();
    @(posedge FAB_CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 8 && !REQ_READY; i++) tick();
  endtask

  // Issues one request and watches it to DONE; the flag of the selected line is raised
  // right after the oor_after-th MOVE pulse, and tog_rx toggles the RX flag every cycle.
  task automatic run(input logic sel, input logic dir, input logic ld, input logic [7:0] cnt,
                     input int oor_after, input bit tog_rx);
    logic prev_pause;
    wait_ready();
    REQ_SEL = sel; REQ_DIR = dir; REQ_LOAD = ld; REQ_COUNT = cnt; REQ_VALID = 1'b1;
    n_move = 0; n_load = 0; n_pause = 0; done_cyc = -1; first_mv = -1; last_mv = -1;
    min_gap = 9999; max_gap = 0; viol = 0; pause_rises = 0; first_pause = -1; last_pause = -1;
    prev_pause = 1'b0;
    tick();
    REQ_VALID = 1'b0;
    for (int c = 1; c <= 2000 && done_cyc < 0; c++) begin
      if (DELAY_LINE_MOVE) begin
        n_move++;
        if (first_mv < 0) first_mv = c;
        else begin
          if (c - last_mv < min_gap) min_gap = c - last_mv;
          if (c - last_mv > max_gap) max_gap = c - last_mv;
        end
        last_mv = c;
      end
      if (DELAY_LINE_LOAD) n_load++;
      if (HS_IO_CLK_PAUSE) begin
        n_pause++;
        if (first_pause < 0) first_pause = c;
        last_pause = c;
        if (!prev_pause) pause_rises++;
      end
      prev_pause = HS_IO_CLK_PAUSE;
      if (((DELAY_LINE_LOAD || DELAY_LINE_MOVE) && !HS_IO_CLK_PAUSE) ||
          (DELAY_LINE_LOAD && DELAY_LINE_MOVE)) viol++;
      if (DONE) begin
        done_cyc = c;
      end else begin
        if (oor_after >= 0 && DELAY_LINE_MOVE && n_move == oor_after) begin
          if (sel) TX_DELAY_LINE_OUT_OF_RANGE = 1'b1;
          else     RX_DELAY_LINE_OUT_OF_RANGE = 1'b1;
        end
        if (tog_rx) RX_DELAY_LINE_OUT_OF_RANGE = ~RX_DELAY_LINE_OUT_OF_RANGE;
        tick();
      end
    end
    RX_DELAY_LINE_OUT_OF_RANGE = 1'b0;
    TX_DELAY_LINE_OUT_OF_RANGE = 1'b0;
  endtask

  initial begin
    int d1, acc2, d2, low_cnt, oor_c1;

    // Reset state
    RESET_N = 1'b0;
    tick(); tick();
    check("rst_ready", REQ_READY, 1);
    check("rst_pause", HS_IO_CLK_PAUSE, 0);
    check("rst_pulses", {DELAY_LINE_LOAD, DELAY_LINE_MOVE, DONE, OOR}, 0);
    check("rst_sel_dir", {DELAY_LINE_SEL, DELAY_LINE_DIRECTION}, 0);
    check("rst_steps", STEPS_DONE, 0);
    RESET_N = 1'b1;
    tick();

    // RX, up, 4 moves: moves at 4,7,10,13; pause 1..16; DONE at 18
    run(1'b0, 1'b1, 1'b0, 8'd4, -1, 1'b0);
    check("t1_moves", n_move, 4);
    check("t1_first_move", first_mv, 4);
    check("t1_min_spacing", min_gap, 3);
    check("t1_max_spacing", max_gap, 3);
    check("t1_pause_cycles", n_pause, 16);
    check("t1_pause_first", first_pause, 1);
    check("t1_pause_rises", pause_rises, 1);
    check("t1_done_cyc", done_cyc, 18);
    check("t1_steps", STEPS_DONE, 4);
    check("t1_oor", OOR, 0);
    check("t1_loads", n_load, 0);
    check("t1_viol", viol, 0);
    check("t1_dir", DELAY_LINE_DIRECTION, 1);
    tick();
    check("t1_ready_after_done", REQ_READY, 1);

    // LOAD only: load at 4, hold 5..7, DONE at 9
    run(1'b0, 1'b0, 1'b1, 8'd0, -1, 1'b0);
    check("t2_loads", n_load, 1);
    check("t2_moves", n_move, 0);
    check("t2_pause_cycles", n_pause, 7);
    check("t2_done_cyc", done_cyc, 9);
    check("t2_steps", STEPS_DONE, 0);
    check("t2_viol", viol, 0);

    // LOAD then 2 moves: load 4, moves 7 and 10, DONE at 15
    run(1'b0, 1'b1, 1'b1, 8'd2, -1, 1'b0);
    check("t2b_loads", n_load, 1);
    check("t2b_first_move", first_mv, 7);
    check("t2b_moves", n_move, 2);
    check("t2b_done_cyc", done_cyc, 15);
    check("t2b_viol", viol, 0);

    // TX, 10 moves, TX flag up after 3rd move, RX toggling: stop at 3, hold 13..15, DONE 17
    run(1'b1, 1'b1, 1'b0, 8'd10, 3, 1'b1);
    check("t3_moves", n_move, 3);
    check("t3_steps", STEPS_DONE, 3);
    check("t3_oor", OOR, 1);
    check("t3_last_pause", last_pause, 15);
    check("t3_done_cyc", done_cyc, 17);
    check("t3_sel", DELAY_LINE_SEL, 1);
    check("t3_viol", viol, 0);

    // RX, 1 move, flag rises during HOLD: OOR latches there, DONE at 9
    run(1'b0, 1'b1, 1'b0, 8'd1, 1, 1'b0);
    check("t4_steps", STEPS_DONE, 1);
    check("t4_oor_hold", OOR, 1);
    check("t4_done_cyc", done_cyc, 9);
    tick(); tick(); tick();
    check("t4_oor_held", OOR, 1);

    // Back-to-back with REQ_VALID held: DONE 9, second accept 10, second DONE 19
    wait_ready();
    REQ_SEL = 1'b0; REQ_DIR = 1'b1; REQ_LOAD = 1'b0; REQ_COUNT = 8'd1; REQ_VALID = 1'b1;
    tick();
    d1 = -1; acc2 = -1; d2 = -1; low_cnt = 0; oor_c1 = OOR;
    for (int c = 1; c <= 60 && d2 < 0; c++) begin
      if (DONE && d1 < 0) d1 = c;
      else if (DONE && d1 >= 0) d2 = c;
      if (acc2 < 0 && !HS_IO_CLK_PAUSE && c > 1) low_cnt++;
      if (d1 >= 0 && acc2 < 0 && REQ_READY) acc2 = c;
      if (acc2 >= 0 && c == acc2 + 1) REQ_VALID = 1'b0;
      if (d2 < 0) tick();
    end
    REQ_VALID = 1'b0;
    check("b2b_oor_cleared", oor_c1, 0);
    check("b2b_done1", d1, 9);
    check("b2b_accept2", acc2, 10);
    check("b2b_pause_low", low_cnt, 3);
    check("b2b_done2", d2, 19);

    // Reset in GAP: cycle 5 is the first gap cycle
    wait_ready();
    REQ_SEL = 1'b0; REQ_DIR = 1'b1; REQ_LOAD = 1'b0; REQ_COUNT = 8'd4; REQ_VALID = 1'b1;
    tick();
    REQ_VALID = 1'b0;
    tick(); tick(); tick(); tick();
    check("gap_pause", HS_IO_CLK_PAUSE, 1);
    check("gap_steps", STEPS_DONE, 1);
    RESET_N = 1'b0;
    tick();
    check("rstmid_pause", HS_IO_CLK_PAUSE, 0);
    check("rstmid_pulses", {DELAY_LINE_LOAD, DELAY_LINE_MOVE}, 0);
    check("rstmid_ready", REQ_READY, 1);
    check("rstmid_steps", STEPS_DONE, 0);
    RESET_N = 1'b1;
    tick();
    check("rstmid_still_idle", HS_IO_CLK_PAUSE, 0);
    run(1'b0, 1'b1, 1'b0, 8'd2, -1, 1'b0);
    check("post_rst_done_cyc", done_cyc, 12);
    check("post_rst_steps", STEPS_DONE, 2);
`ifdef DLY_POS_TRACK_EN
    check("pos_rx_after_rst", RX_TAP_POS, 2);
    check("pos_tx_after_rst", TX_TAP_POS, 0);
`endif

    // Full count: 255 moves, no wrap; DONE at 3+255+508+3+2
    run(1'b0, 1'b0, 1'b0, 8'd255, -1, 1'b0);
    check("max_moves", n_move, 255);
    check("max_steps", STEPS_DONE, 255);
    check("max_done_cyc", done_cyc, 771);
    check("max_viol", viol, 0);

`ifdef DLY_POS_TRACK_EN
    check("pos_rx_sat0", RX_TAP_POS, 0);
    run(1'b0, 1'b1, 1'b1, 8'd0, -1, 1'b0);
    check("pos_rx_load", RX_TAP_POS, 0);
    run(1'b0, 1'b1, 1'b0, 8'd5, -1, 1'b0);
    check("pos_rx_up5", RX_TAP_POS, 5);
    run(1'b0, 1'b0, 1'b0, 8'd7, -1, 1'b0);
    check("pos_rx_down7", RX_TAP_POS, 0);
    check("pos_tx_same", TX_TAP_POS, 0);
`endif

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
